// File: rtl/ip2dma_upsizer_if.sv
// ip2dma_upsizer_if
// Bundles the narrow IP-side stream and the wide DMA MM2S AXI-Stream port of
// the upsizer. The signal names match the IP core and the AXI DMA.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where the producer's valid and the consumer's ready are both high. A producer
// holding valid must keep its data/keep/last stable until the transfer. The
// upsizer's ready never depends on its own input valid.
//
// Modports:
//   slave  - the upsizer's view: consumes dout/valid/keep/last, drives ready,
//            produces m_axis_mm2s_tdata/tkeep/tlast/tvalid, consumes tready.
//   master - the surrounding system's view (IP FIFO + DMA), the mirror image.
interface ip2dma_upsizer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128
);
  logic [IN_W-1:0]    dout;
  logic               valid;
  logic               ready;
  logic [IN_W/8-1:0]  keep;
  logic               last;
  logic [OUT_W-1:0]   m_axis_mm2s_tdata;
  logic [OUT_W/8-1:0] m_axis_mm2s_tkeep;
  logic               m_axis_mm2s_tlast;
  logic               m_axis_mm2s_tready;
  logic               m_axis_mm2s_tvalid;

  modport slave (
    input  dout, valid, keep, last, m_axis_mm2s_tready,
    output ready, m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast,
           m_axis_mm2s_tvalid
  );

  modport master (
    output dout, valid, keep, last, m_axis_mm2s_tready,
    input  ready, m_axis_mm2s_tdata, m_axis_mm2s_tkeep, m_axis_mm2s_tlast,
           m_axis_mm2s_tvalid
  );
endinterface

// File: rtl/ip2dma_upsizer.sv
// ip2dma_upsizer
// Packs consecutive IN_W-bit IP beats into OUT_W-bit beats for the AXI DMA
// MM2S stream port. Lanes fill little-endian (first beat in the low lane).
// A word is emitted when the top lane fills or when the IP marks last; unused
// upper lanes of an early-terminated word carry zero data and zero keep. The
// output stage is a single register slice. tlast can be forced every
// MAX_BEATS output words (0 disables), and pkt_count counts tlast transfers.
//
// Ports:
//   m_axis_mm2s_aclk - clock for all logic
//   reset            - asynchronous active-low reset
//   bus              - ip2dma_upsizer_if.slave (IP input stream + DMA output)
//   pkt_count        - tlast beats transferred to the DMA, wraps
//   dbg_lane         - current lane index of the packing accumulator
module ip2dma_upsizer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 128,
  parameter int MAX_BEATS = 0,
  parameter int CNT_W     = 16,
  localparam int RATIO    = OUT_W / IN_W,
  localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  m_axis_mm2s_aclk,
  input  logic                  reset,
  ip2dma_upsizer_if.slave       bus,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [LANE_W-1:0]     dbg_lane
);

  localparam int IKW    = IN_W / 8;
  localparam int OKW    = OUT_W / 8;
  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  acc_data;
  logic [OKW-1:0]    acc_keep;
  logic [BEAT_W-1:0] beat_cnt;
  logic [OUT_W-1:0]  out_data;
  logic [OKW-1:0]    out_keep;
  logic              out_last;
  logic              out_valid;
  logic [CNT_W-1:0]  pkt_cnt_q;

  logic              ready_int;
  logic              accept;
  logic              complete;
  logic              force_last;
  logic              word_last;
  logic [OUT_W-1:0]  word_data;
  logic [OKW-1:0]    word_keep;

  // The output register can take a new word whenever it is empty or being
  // drained this cycle.
  assign ready_int = !out_valid || bus.m_axis_mm2s_tready;
  assign accept    = bus.valid && ready_int;
  assign complete  = accept && (bus.last || (lane == LANE_MAX));

  assign force_last = (MAX_BEATS != 0) && (beat_cnt == BEAT_MAX);
  assign word_last  = bus.last || force_last;

  // Accumulator with the current beat merged into its lane. Lanes above the
  // current one are still zero because the accumulator is cleared on every
  // completed word, which gives the zero padding for an early last.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        word_data[i*IN_W +: IN_W] = bus.dout;
        word_keep[i*IKW +: IKW]   = bus.keep;
      end
    end
  end

  always_ff @(posedge m_axis_mm2s_aclk or negedge reset) begin
    if (!reset) begin
      lane      <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      if (complete) begin
        // Loading a new word; any word in the output stage is leaving this
        // same cycle because ready_int implies it was empty or drained.
        out_data  <= word_data;
        out_keep  <= word_keep;
        out_last  <= word_last;
        out_valid <= 1'b1;
        lane      <= '0;
        acc_data  <= '0;
        acc_keep  <= '0;
        beat_cnt  <= word_last ? '0 : beat_cnt + 1'b1;
      end else begin
        if (accept) begin
          acc_data <= word_data;
          acc_keep <= word_keep;
          lane     <= lane + 1'b1;
        end
        if (out_valid && bus.m_axis_mm2s_tready) begin
          out_valid <= 1'b0;
        end
      end

      if (out_valid && bus.m_axis_mm2s_tready && out_last) begin
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
    end
  end

  assign bus.ready              = ready_int;
  assign bus.m_axis_mm2s_tdata  = out_data;
  assign bus.m_axis_mm2s_tkeep  = out_keep;
  assign bus.m_axis_mm2s_tlast  = out_last;
  assign bus.m_axis_mm2s_tvalid = out_valid;
  assign pkt_count              = pkt_cnt_q;
  assign dbg_lane               = lane;

endmodule

// File: tb/tb_ip2dma_upsizer.sv
// tb_ip2dma_upsizer
// Directed bench for ip2dma_upsizer. Three instances share one clock and
// reset: a_* (defaults, 32->128), b_* (32->128 with MAX_BEATS=4) and
// c_* (64->64 pass-through). Inputs change 1 time unit after the rising edge,
// outputs are sampled at that same point.
module tb_ip2dma_upsizer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ip2dma_upsizer_if #(.IN_W(32), .OUT_W(128)) a_if ();
  ip2dma_upsizer_if #(.IN_W(32), .OUT_W(128)) b_if ();
  ip2dma_upsizer_if #(.IN_W(64), .OUT_W(64))  c_if ();

  logic [15:0] a_pkt, b_pkt, c_pkt;
  logic [1:0]  a_lane, b_lane;
  logic        c_lane;

  ip2dma_upsizer #(.IN_W(32), .OUT_W(128), .MAX_BEATS(0), .CNT_W(16)) u_a (
    .m_axis_mm2s_aclk(clk), .reset(rst_n), .bus(a_if.slave),
    .pkt_count(a_pkt), .dbg_lane(a_lane)
  );

  ip2dma_upsizer #(.IN_W(32), .OUT_W(128), .MAX_BEATS(4), .CNT_W(16)) u_b (
    .m_axis_mm2s_aclk(clk), .reset(rst_n), .bus(b_if.slave),
    .pkt_count(b_pkt), .dbg_lane(b_lane)
  );

  ip2dma_upsizer #(.IN_W(64), .OUT_W(64), .MAX_BEATS(0), .CNT_W(16)) u_c (
    .m_axis_mm2s_aclk(clk), .reset(rst_n), .bus(c_if.slave),
    .pkt_count(c_pkt), .dbg_lane(c_lane)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat on instance a, assuming ready is high at the edge.
  task automatic send_a(input logic [31:0] d, input logic l);
    a_if.dout  = d;
    a_if.keep  = 4'hF;
    a_if.last  = l;
    a_if.valid = 1'b1;
    tick();
    a_if.valid = 1'b0;
    a_if.last  = 1'b0;
  endtask

  // Expected 128-bit word for four consecutive beats starting at value v.
  function automatic logic [127:0] pack4(input logic [31:0] v);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = v + 32'(i);
    return w;
  endfunction

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [63:0]  c_vals[3];
    logic [63:0]  last_in;
    logic         in_hs, out_hs;
    int           sent, rcvd, b_outs;

    total = 0;
    bad   = 0;
    c_vals[0] = 64'h0123_4567_89AB_CDEF;
    c_vals[1] = 64'hFEDC_BA98_7654_3210;
    c_vals[2] = 64'h5A5A_A5A5_0F0F_F0F0;

    a_if.dout = '0; a_if.valid = 0; a_if.keep = '0; a_if.last = 0; a_if.m_axis_mm2s_tready = 1;
    b_if.dout = '0; b_if.valid = 0; b_if.keep = '0; b_if.last = 0; b_if.m_axis_mm2s_tready = 1;
    c_if.dout = '0; c_if.valid = 0; c_if.keep = '0; c_if.last = 0; c_if.m_axis_mm2s_tready = 0;

    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_tvalid", a_if.m_axis_mm2s_tvalid, 0);
    check("rst_tdata",  a_if.m_axis_mm2s_tdata, 0);
    check("rst_tkeep",  a_if.m_axis_mm2s_tkeep, 0);
    check("rst_tlast",  a_if.m_axis_mm2s_tlast, 0);
    check("rst_pkt",    a_pkt, 0);
    check("rst_ready",  a_if.ready, 1);
    rst_n = 1'b1;
    tick();

    // ---- full 4-beat packet ----
    send_a(32'h1111_1111, 0);
    send_a(32'h2222_2222, 0);
    send_a(32'h3333_3333, 0);
    check("full_no_early_valid", a_if.m_axis_mm2s_tvalid, 0);
    check("full_lane3", a_lane, 3);
    send_a(32'h4444_4444, 1);
    check("full_tvalid", a_if.m_axis_mm2s_tvalid, 1);
    check("full_tdata",  a_if.m_axis_mm2s_tdata, 128'h44444444_33333333_22222222_11111111);
    check("full_tkeep",  a_if.m_axis_mm2s_tkeep, 16'hFFFF);
    check("full_tlast",  a_if.m_axis_mm2s_tlast, 1);
    tick();
    check("full_pkt", a_pkt, 1);
    check("full_drained", a_if.m_axis_mm2s_tvalid, 0);

    // ---- early last ----
    send_a(32'hAAAA_0001, 0);
    send_a(32'hAAAA_0002, 1);
    check("early_tvalid", a_if.m_axis_mm2s_tvalid, 1);
    check("early_tdata",  a_if.m_axis_mm2s_tdata, 128'h00000000_00000000_AAAA0002_AAAA0001);
    check("early_tkeep",  a_if.m_axis_mm2s_tkeep, 16'h00FF);
    check("early_tlast",  a_if.m_axis_mm2s_tlast, 1);
    check("early_lane0",  a_lane, 0);
    tick();
    check("early_pkt", a_pkt, 2);

    // ---- backpressure ----
    a_if.m_axis_mm2s_tready = 0;
    send_a(32'h5555_5555, 0);
    send_a(32'h6666_6666, 0);
    send_a(32'h7777_7777, 0);
    send_a(32'h8888_8888, 1);
    check("bp_loaded", a_if.m_axis_mm2s_tvalid, 1);
    a_if.dout  = 32'h9999_9999;
    a_if.keep  = 4'hF;
    a_if.last  = 1'b1;
    a_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready_low", a_if.ready, 0);
      check("bp_hold_data", a_if.m_axis_mm2s_tdata, 128'h88888888_77777777_66666666_55555555);
      check("bp_hold_last", a_if.m_axis_mm2s_tlast, 1);
      check("bp_hold_valid", a_if.m_axis_mm2s_tvalid, 1);
      tick();
    end
    a_if.m_axis_mm2s_tready = 1;
    #1;
    check("bp_ready_same_cycle", a_if.ready, 1);
    tick();
    a_if.valid = 0;
    a_if.last  = 0;
    check("bp_reload_valid", a_if.m_axis_mm2s_tvalid, 1);
    check("bp_reload_data",  a_if.m_axis_mm2s_tdata, 128'h0000_0000_0000_0000_0000_0000_9999_9999);
    check("bp_reload_keep",  a_if.m_axis_mm2s_tkeep, 16'h000F);
    check("bp_pkt3", a_pkt, 3);
    tick();
    check("bp_pkt4", a_pkt, 4);
    check("bp_drained", a_if.m_axis_mm2s_tvalid, 0);

    // ---- reset mid-packet ----
    send_a(32'hBAD0_0000, 0);
    send_a(32'hBAD0_0001, 0);
    send_a(32'hBAD0_0002, 0);
    check("mid_lane3", a_lane, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", a_if.m_axis_mm2s_tvalid, 0);
    check("mid_rst_tdata",  a_if.m_axis_mm2s_tdata, 0);
    check("mid_rst_pkt",    a_pkt, 0);
    check("mid_rst_lane",   a_lane, 0);
    #1;
    rst_n = 1'b1;
    tick();
    send_a(32'hC000_0001, 0);
    send_a(32'hC000_0002, 0);
    send_a(32'hC000_0003, 0);
    send_a(32'hC000_0004, 1);
    check("post_rst_tdata", a_if.m_axis_mm2s_tdata, pack4(32'hC000_0001));
    check("post_rst_tkeep", a_if.m_axis_mm2s_tkeep, 16'hFFFF);
    check("post_rst_tlast", a_if.m_axis_mm2s_tlast, 1);
    tick();
    check("post_rst_pkt", a_pkt, 1);

    // ---- forced tlast every 4 output beats ----
    b_outs = 0;
    b_if.keep = 4'hF;
    for (int i = 0; i < 24; i++) begin
      b_if.dout  = 32'(i + 1);
      b_if.last  = (i == 23);
      b_if.valid = 1'b1;
      tick();
      if (b_if.m_axis_mm2s_tvalid) b_outs++;
      if (i % 4 == 3) begin
        check("mb_tvalid", b_if.m_axis_mm2s_tvalid, 1);
        check("mb_tdata",  b_if.m_axis_mm2s_tdata, pack4(32'(i - 2)));
        check("mb_tlast",  b_if.m_axis_mm2s_tlast, (i == 15 || i == 23) ? 1'b1 : 1'b0);
      end
      if (i == 19) check("mb_pkt_after_20", b_pkt, 1);
    end
    b_if.valid = 0;
    b_if.last  = 0;
    tick();
    check("mb_out_beats", b_outs, 6);
    check("mb_pkt", b_pkt, 2);

    // ---- 64->64 pass-through with toggling tready ----
    sent = 0;
    rcvd = 0;
    last_in = '0;
    c_if.keep = 8'hFF;
    for (int cyc = 0; cyc < 20 && rcvd < 3; cyc++) begin
      c_if.m_axis_mm2s_tready = (cyc % 2 == 1);
      c_if.valid = (sent < 3);
      c_if.dout  = (sent < 3) ? c_vals[sent] : '0;
      #1;
      out_hs = c_if.m_axis_mm2s_tvalid && c_if.m_axis_mm2s_tready;
      in_hs  = c_if.valid && c_if.ready;
      if (out_hs) begin
        rcvd++;
        if (exp_q.size() == 0) check("pt_spurious", 1, 0);
        else check("pt_data", c_if.m_axis_mm2s_tdata, exp_q.pop_front());
      end
      if (in_hs) begin
        exp_q.push_back(c_if.dout);
        last_in = c_if.dout;
        sent++;
      end
      tick();
      if (in_hs) begin
        check("pt_lat_valid", c_if.m_axis_mm2s_tvalid, 1);
        check("pt_lat_data",  c_if.m_axis_mm2s_tdata, last_in);
        check("pt_lat_keep",  c_if.m_axis_mm2s_tkeep, 8'hFF);
      end
    end
    c_if.valid = 0;
    c_if.m_axis_mm2s_tready = 1;
    check("pt_sent", sent, 3);
    check("pt_rcvd", rcvd, 3);
    check("pt_queue_empty", exp_q.size(), 0);
    repeat (2) tick();
    check("pt_no_dup", c_if.m_axis_mm2s_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip2dma_upsizer.md
Name: ip2dma_upsizer

Overview:
Parametrised successor to the combinational IP-to-DMA stream adapter. It accepts a narrow IP-side stream (dout/valid/ready/keep/last) and packs consecutive beats into full-width beats on the DMA MM2S AXI-Stream port, with a registered output stage. It can force tlast after a configurable beat count and keeps a running count of transferred packets. It sits between an accelerator's output FIFO and the AXI DMA stream slave.

Parameters:
IN_W, 32, IP-side data width in bits; multiple of 8.
OUT_W, 128, DMA-side data width in bits; OUT_W/IN_W (RATIO) is an integer power of two >= 1.
MAX_BEATS, 0, output beats per packet before tlast is forced; 0 disables forcing.
CNT_W, 16, width of pkt_count.

Ports:
m_axis_mm2s_aclk  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset
dout  in  IN_W  IP-side data
valid  in  1  IP-side beat valid
ready  out  1  IP-side beat accepted when valid&&ready
keep  in  IN_W/8  IP-side byte enables
last  in  1  IP-side end of packet
m_axis_mm2s_tdata  out  OUT_W  packed data
m_axis_mm2s_tkeep  out  OUT_W/8  packed byte enables
m_axis_mm2s_tlast  out  1  end of packet
m_axis_mm2s_tready  in  1  DMA ready
m_axis_mm2s_tvalid  out  1  output beat valid
pkt_count  out  CNT_W  number of tlast beats transferred; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async assert, sync deassert): tvalid=0, tdata=0, tkeep=0, tlast=0, pkt_count=0, lane index=0, accumulator and keep accumulator cleared, beat counter=0. A partial word in flight is discarded.
- ready = !tvalid || m_axis_mm2s_tready; combinational, no dependency on valid.
- Lane packing: the first accepted beat of a word goes to bits [IN_W-1:0] (little-endian lanes) and the lane index increments per accepted beat.
- Word completes on an accepted beat with lane index == RATIO-1, or with last=1. On completion, the word plus that beat's lane are registered into the output stage; tvalid rises the next cycle (latency 1 cycle from the final input handshake). The lane index returns to 0.
- Early last: unfilled upper lanes carry tdata=0 and tkeep=0.
- Output stage holds tdata/tkeep/tlast stable while tvalid && !tready. It clears tvalid on tready unless a new word is loaded the same cycle. Back-to-back transfer sustains one input beat per cycle when tready=1.
- tlast = input last of the completing beat OR (MAX_BEATS!=0 && beat counter == MAX_BEATS-1).
- Beat counter increments per completed word and resets to 0 on any word loaded with tlast=1. Input last together with the forced limit yields one tlast, and both reset the counter.
- Forced tlast does not drop data; subsequent input continues as a new packet.
- pkt_count increments on each cycle where tvalid && tready && tlast.
- RATIO=1: registered pass-through, 1-cycle latency, same handshake rules.
- valid=1 with keep=0 is accepted and packed as-is. No protocol checking.

Test Plan:
- Defaults with tready=1: 4 beats 0x11111111..0x44444444, keep=0xF, last on the 4th -> one beat tdata=0x44444444_33333333_22222222_11111111, tkeep=0xFFFF, tlast=1 one cycle after the 4th handshake; pkt_count=1.
- Early last: 2 beats 0xAAAA0001, 0xAAAA0002 with last on the 2nd -> tdata=0x...0000_0000_AAAA0002_AAAA0001, tkeep=0x00FF, tlast=1, lane index back to 0.
- Backpressure: hold tready=0 for 5 cycles with tvalid=1 -> ready=0, tdata/tkeep/tlast unchanged for all 5 cycles. Raise tready -> beat accepted, ready=1 the same cycle.
- MAX_BEATS=4: stream 20 input beats with no last -> 5 output beats, tlast on output beats 4 only (and pending word in accumulator); then last on beat 24 -> 6th beat tlast=1; pkt_count=2.
- Reset mid-operation: accept 3 beats, assert reset -> tvalid=0 immediately. After release, 4 new beats -> output contains only the new data with tkeep=0xFFFF.
- IN_W=OUT_W=64: 3 beats with tready toggling 1/0 each cycle -> data in order, 1-cycle latency, no loss or duplication.
